// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: register-file geometry and the machine word type
// used by the register file, ALU and data memory.
package mips_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;

  localparam int REG_COUNT = 2 ** DEF_ADDR_WIDTH;
  localparam int REG_ZERO  = 0;
  localparam int REG_RA    = 31;

  typedef logic [DEF_DATA_WIDTH-1:0] word_t;

endpackage : mips_pkg

// File: rtl/reg_file_if.sv
// Register-file port bundle: control/index/writeback signals from the datapath,
// read data back to the ALU operand paths.
interface reg_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);

  logic                  RegWrite;
  logic [ADDR_WIDTH-1:0] ReadReg1;
  logic [ADDR_WIDTH-1:0] ReadReg2;
  logic [ADDR_WIDTH-1:0] WriteReg;
  logic [DATA_WIDTH-1:0] WriteData;
  logic [DATA_WIDTH-1:0] ReadData1;
  logic [DATA_WIDTH-1:0] ReadData2;

  modport master (
    output RegWrite, ReadReg1, ReadReg2, WriteReg, WriteData,
    input  ReadData1, ReadData2
  );

  modport slave (
    input  RegWrite, ReadReg1, ReadReg2, WriteReg, WriteData,
    output ReadData1, ReadData2
  );

endinterface : reg_file_if

// File: rtl/regfile_bypass_mux.sv
// Per-read-port write-to-read forwarding: returns the in-flight WriteData when the
// port addresses the register being written. Only built with REGFILE_BYPASS_EN.
`ifdef REGFILE_BYPASS_EN
module regfile_bypass_mux #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  rst,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_idx,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_idx,
  input  logic [DATA_WIDTH-1:0] stored_data,
  output logic [DATA_WIDTH-1:0] read_data
);

  logic hit;

  // write_en already excludes register 0, so r0 can never be forwarded.
  assign hit       = !rst && write_en && (write_idx == read_idx);
  assign read_data = hit ? write_data : stored_data;

endmodule : regfile_bypass_mux
`endif

// File: rtl/reg_file.sv
// MIPS register file: 2**ADDR_WIDTH x DATA_WIDTH, two combinational read ports,
// one synchronous write port, r0 hardwired to zero. Optional bypass: REGFILE_BYPASS_EN.
module reg_file
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  reg_file_if.slave  bus
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] entry [NUM_REGS];
  logic                  write_en;
  logic [DATA_WIDTH-1:0] stored1;
  logic [DATA_WIDTH-1:0] stored2;

  assign write_en = bus.RegWrite && (bus.WriteReg != '0);

  // Entry 0 is a constant, so reads of r0 need no special case in the read mux.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
    if (gi == REG_ZERO) begin : g_zero
      assign entry[gi] = '0;
    end else begin : g_store
      logic [DATA_WIDTH-1:0] value_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          value_reg <= '0;
        end else if (write_en && (bus.WriteReg == ADDR_WIDTH'(gi))) begin
          value_reg <= bus.WriteData;
        end
      end

      assign entry[gi] = value_reg;
    end
  end

  assign stored1 = entry[bus.ReadReg1];
  assign stored2 = entry[bus.ReadReg2];

`ifdef REGFILE_BYPASS_EN
  regfile_bypass_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bypass1 (
    .rst         (rst),
    .write_en    (write_en),
    .write_idx   (bus.WriteReg),
    .write_data  (bus.WriteData),
    .read_idx    (bus.ReadReg1),
    .stored_data (stored1),
    .read_data   (bus.ReadData1)
  );

  regfile_bypass_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bypass2 (
    .rst         (rst),
    .write_en    (write_en),
    .write_idx   (bus.WriteReg),
    .write_data  (bus.WriteData),
    .read_idx    (bus.ReadReg2),
    .stored_data (stored2),
    .read_data   (bus.ReadData2)
  );
`else
  // Old value until the edge commits: keeps WriteData -> ReadData free of a loop.
  assign bus.ReadData1 = stored1;
  assign bus.ReadData2 = stored2;
`endif

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: reset, write/read, r0 guard,
// read-during-write (either build), write-enable low and a full register sweep.
module tb_reg_file;
  import mips_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  reg_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rf_if ();

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (rf_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Advance past the next rising edge; inputs change 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] idx, input logic [31:0] val);
    rf_if.RegWrite  = 1'b1;
    rf_if.WriteReg  = idx;
    rf_if.WriteData = val;
    tick();
    rf_if.RegWrite  = 1'b0;
  endtask

  task automatic read_pair(input logic [4:0] a, input logic [4:0] b);
    rf_if.ReadReg1 = a;
    rf_if.ReadReg2 = b;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp1;
    logic [31:0] exp2;
    logic [31:0] rdw_before;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    rf_if.RegWrite  = 1'b0;
    rf_if.ReadReg1  = '0;
    rf_if.ReadReg2  = '0;
    rf_if.WriteReg  = '0;
    rf_if.WriteData = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    read_pair(5'd1, 5'd31);
    check("reset_r1", rf_if.ReadData1, 32'h0);
    check("reset_r31", rf_if.ReadData2, 32'h0);

    // Test 1: reset discards contents and ignores a same-cycle write
    write_reg(5'd5, 32'h12345678);
    read_pair(5'd5, 5'd7);
    check("preload_r5", rf_if.ReadData1, 32'h12345678);
    rst = 1'b1;
    rf_if.RegWrite  = 1'b1;
    rf_if.WriteReg  = 5'd7;
    rf_if.WriteData = 32'hFFFFFFFF;
    tick();
    rst = 1'b0;
    rf_if.RegWrite = 1'b0;
    read_pair(5'd5, 5'd7);
    check("rst_r5", rf_if.ReadData1, 32'h0);
    check("rst_r7", rf_if.ReadData2, 32'h0);

    // Test 2: consecutive writes, then ALU-style add
    write_reg(5'd8, 32'h0000000A);
    write_reg(5'd9, 32'h00000003);
    read_pair(5'd8, 5'd9);
    check("rd_r8", rf_if.ReadData1, 32'h0000000A);
    check("rd_r9", rf_if.ReadData2, 32'h00000003);
    check("add_r8_r9", rf_if.ReadData1 + rf_if.ReadData2, 32'h0000000D);

    // Test 3: writes to r0 are dropped, before and after the edge
    rf_if.RegWrite  = 1'b1;
    rf_if.WriteReg  = 5'd0;
    rf_if.WriteData = 32'hDEADBEEF;
    read_pair(5'd0, 5'd0);
    check("r0_before", rf_if.ReadData1, 32'h0);
    tick();
    rf_if.RegWrite = 1'b0;
    read_pair(5'd0, 5'd8);
    check("r0_after", rf_if.ReadData1, 32'h0);
    check("r8_kept", rf_if.ReadData2, 32'h0000000A);

    // Test 4: read-during-write on both ports
    write_reg(5'd3, 32'h00000011);
`ifdef REGFILE_BYPASS_EN
    rdw_before = 32'h00000022;
`else
    rdw_before = 32'h00000011;
`endif
    rf_if.RegWrite  = 1'b1;
    rf_if.WriteReg  = 5'd3;
    rf_if.WriteData = 32'h00000022;
    read_pair(5'd3, 5'd3);
    check("rdw_p1_before", rf_if.ReadData1, rdw_before);
    check("rdw_p2_before", rf_if.ReadData2, rdw_before);
    tick();
    rf_if.RegWrite = 1'b0;
    #1;
    check("rdw_p1_after", rf_if.ReadData1, 32'h00000022);
    check("rdw_p2_after", rf_if.ReadData2, 32'h00000022);

    // Test 5: RegWrite low leaves r31 untouched
    write_reg(5'(REG_RA), 32'h00400000);
    rf_if.RegWrite  = 1'b0;
    rf_if.WriteReg  = 5'(REG_RA);
    rf_if.WriteData = 32'hAAAAAAAA;
    read_pair(5'(REG_RA), 5'(REG_RA));
    check("we_low_before", rf_if.ReadData1, 32'h00400000);
    tick();
    #1;
    check("we_low_after", rf_if.ReadData2, 32'h00400000);

    // Test 6: sweep every register, read pairs (i, 32-i)
    for (int i = 1; i < REG_COUNT; i++) begin
      write_reg(5'(i), 32'(i) * 32'h01010101);
    end
    for (int i = 0; i < REG_COUNT; i++) begin
      int j;
      j = (REG_COUNT - i) % REG_COUNT;
      read_pair(5'(i), 5'(j));
      exp1 = 32'(i) * 32'h01010101;
      exp2 = 32'(j) * 32'h01010101;
      check($sformatf("sweep_p1_r%0d", i), rf_if.ReadData1, exp1);
      check($sformatf("sweep_p2_r%0d", j), rf_if.ReadData2, exp2);
    end

    // Reset mid-operation clears the swept contents
    rst = 1'b1;
    tick();
    rst = 1'b0;
    read_pair(5'd16, 5'd31);
    check("rst2_r16", rf_if.ReadData1, 32'h0);
    check("rst2_r31", rf_if.ReadData2, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_reg_file
